// File: rtl/pipeline_ctrl_if.sv
// Pipeline hazard/stall control bus.
// Groups the hazard-detection inputs coming from the datapath and the
// enable/flush/status outputs produced by the controller.
//   master : datapath side (drives hazard info, observes control)
//   slave  : controller side (pipeline_ctrl)
interface pipeline_ctrl_if;
  // hazard / memory status from the datapath
  logic [4:0]  id_rs1_addr;
  logic [4:0]  id_rs2_addr;
  logic        id_uses_rs1;
  logic        id_uses_rs2;
  logic        ex_mem_read;
  logic [4:0]  ex_rd_addr;
  logic        ex_branch_taken;
  logic        mem_req;
  logic        mem_ready;
  // pipeline control back to the datapath
  logic        pc_en;
  logic        pc_sel_branch;
  logic        ifid_en;
  logic        ifid_flush;
  logic        idex_en;
  logic        idex_flush;
  logic        exmem_en;
  logic        memwb_flush;
  // status
  logic        mem_timeout;
  logic [15:0] stall_cycles;
  logic [15:0] flush_count;

  modport master (
    output id_rs1_addr, id_rs2_addr, id_uses_rs1, id_uses_rs2,
           ex_mem_read, ex_rd_addr, ex_branch_taken, mem_req, mem_ready,
    input  pc_en, pc_sel_branch, ifid_en, ifid_flush, idex_en, idex_flush,
           exmem_en, memwb_flush, mem_timeout, stall_cycles, flush_count
  );

  modport slave (
    input  id_rs1_addr, id_rs2_addr, id_uses_rs1, id_uses_rs2,
           ex_mem_read, ex_rd_addr, ex_branch_taken, mem_req, mem_ready,
    output pc_en, pc_sel_branch, ifid_en, ifid_flush, idex_en, idex_flush,
           exmem_en, memwb_flush, mem_timeout, stall_cycles, flush_count
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// Five-stage pipeline hazard controller.
// Resolves memory freezes, taken-branch flushes and load-use stalls into
// per-stage enable/flush strobes (combinational, zero-cycle latency), and
// flags a sticky error when data memory stalls for too long.
// Ports:
//   clk    : clock
//   reset  : synchronous active-high reset
//   bus    : pipeline_ctrl_if.slave (hazard inputs, control/status outputs)
// Parameter:
//   MEM_TIMEOUT : consecutive MEM_WAIT freeze cycles tolerated (1..65535)
//
// state    | meaning
// ---------+-----------------------------------------------------------
// RUN      | normal issue; hazards handled cycle by cycle
// MEM_WAIT | data memory access outstanding, pipeline frozen, wait_cnt runs
// ERROR    | memory timed out; pipeline held, left only by reset
module pipeline_ctrl #(
  parameter int MEM_TIMEOUT = 255
) (
  input logic           clk,
  input logic           reset,
  pipeline_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_t;

  localparam logic [15:0] TIMEOUT_VAL = 16'(MEM_TIMEOUT);

  state_t      state_q, state_d;
  state_t      cur_state;
  logic [15:0] wait_cnt_q, wait_cnt_d;
  logic [15:0] stall_cycles_q, stall_cycles_d;
  logic [15:0] flush_count_q, flush_count_d;

  logic freeze, load_use;
  logic do_branch, do_load_use;

  logic pc_en, pc_sel_branch, ifid_en, ifid_flush;
  logic idex_en, idex_flush, exmem_en, memwb_flush;

  // While reset is held, outputs behave as if already in RUN.
  assign cur_state = reset ? RUN : state_q;

  assign freeze = (cur_state == RUN || cur_state == MEM_WAIT) &&
                  bus.mem_req && !bus.mem_ready;

  assign load_use = bus.ex_mem_read && (bus.ex_rd_addr != 5'd0) &&
                    ((bus.id_uses_rs1 && bus.id_rs1_addr == bus.ex_rd_addr) ||
                     (bus.id_uses_rs2 && bus.id_rs2_addr == bus.ex_rd_addr));

  // Priority: ERROR > freeze > branch > load_use.
  assign do_branch   = (cur_state != ERROR) && !freeze && bus.ex_branch_taken;
  assign do_load_use = (cur_state != ERROR) && !freeze &&
                       !bus.ex_branch_taken && load_use;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= RUN;
      wait_cnt_q     <= 16'd0;
      stall_cycles_q <= 16'd0;
      flush_count_q  <= 16'd0;
    end else begin
      state_q        <= state_d;
      wait_cnt_q     <= wait_cnt_d;
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
    end
  end

  // Next state and counters
  always_comb begin
    state_d        = state_q;
    wait_cnt_d     = wait_cnt_q;
    stall_cycles_d = stall_cycles_q;
    flush_count_d  = flush_count_q;

    unique case (state_q)
      RUN: begin
        if (freeze) begin
          state_d    = MEM_WAIT;
          wait_cnt_d = 16'd1;
        end
      end
      MEM_WAIT: begin
        if (!freeze) begin
          state_d    = RUN;
          wait_cnt_d = 16'd0;
        end else if (wait_cnt_q == TIMEOUT_VAL) begin
          state_d = ERROR;
        end else begin
          wait_cnt_d = wait_cnt_q + 16'd1;
        end
      end
      ERROR: begin
        state_d = ERROR;
      end
      default: begin
        state_d    = RUN;
        wait_cnt_d = 16'd0;
      end
    endcase

    if ((freeze || do_load_use) && stall_cycles_q != 16'hFFFF)
      stall_cycles_d = stall_cycles_q + 16'd1;
    if (do_branch && flush_count_q != 16'hFFFF)
      flush_count_d = flush_count_q + 16'd1;
  end

  // Pipeline control outputs
  always_comb begin
    pc_en         = 1'b1;
    pc_sel_branch = 1'b0;
    ifid_en       = 1'b1;
    ifid_flush    = 1'b0;
    idex_en       = 1'b1;
    idex_flush    = 1'b0;
    exmem_en      = 1'b1;
    memwb_flush   = 1'b0;

    if (cur_state == ERROR) begin
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      idex_en  = 1'b0;
      exmem_en = 1'b0;
    end else if (freeze) begin
      // Hold everything up to EX/MEM; let MEM/WB drain a bubble.
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_en    = 1'b0;
      memwb_flush = 1'b1;
    end else if (do_branch) begin
      pc_sel_branch = 1'b1;
      ifid_flush    = 1'b1;
      idex_flush    = 1'b1;
    end else if (do_load_use) begin
      // Hold PC and IF/ID, insert one bubble into EX.
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_flush = 1'b1;
    end
  end

  assign bus.pc_en         = pc_en;
  assign bus.pc_sel_branch = pc_sel_branch;
  assign bus.ifid_en       = ifid_en;
  assign bus.ifid_flush    = ifid_flush;
  assign bus.idex_en       = idex_en;
  assign bus.idex_flush    = idex_flush;
  assign bus.exmem_en      = exmem_en;
  assign bus.memwb_flush   = memwb_flush;
  assign bus.mem_timeout   = (cur_state == ERROR);
  assign bus.stall_cycles  = stall_cycles_q;
  assign bus.flush_count   = flush_count_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
module tb_pipeline_ctrl;

  logic clk;
  logic reset;
  logic rst_sat;

  int compared   = 0;
  int mismatched = 0;

  pipeline_ctrl_if bus ();
  pipeline_ctrl_if sbus ();

  pipeline_ctrl #(.MEM_TIMEOUT(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  pipeline_ctrl #(.MEM_TIMEOUT(65535)) u_sat (
    .clk   (clk),
    .reset (rst_sat),
    .bus   (sbus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {pc_en, pc_sel_branch, ifid_en, ifid_flush, idex_en, idex_flush,
  //  exmem_en, memwb_flush, mem_timeout}
  localparam logic [8:0] C_NORMAL = 9'b1_0_1_0_1_0_1_0_0;
  localparam logic [8:0] C_FREEZE = 9'b0_0_0_0_0_0_0_1_0;
  localparam logic [8:0] C_BRANCH = 9'b1_1_1_1_1_1_1_0_0;
  localparam logic [8:0] C_LDUSE  = 9'b0_0_0_0_1_1_1_0_0;
  localparam logic [8:0] C_ERROR  = 9'b0_0_0_0_0_0_0_0_1;

  localparam logic [1:0] S_RUN  = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_ERR  = 2'd2;

  logic [8:0] ctrl;
  assign ctrl = {bus.pc_en, bus.pc_sel_branch, bus.ifid_en, bus.ifid_flush,
                 bus.idex_en, bus.idex_flush, bus.exmem_en, bus.memwb_flush,
                 bus.mem_timeout};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    bus.id_rs1_addr     = 5'd0;
    bus.id_rs2_addr     = 5'd0;
    bus.id_uses_rs1     = 1'b0;
    bus.id_uses_rs2     = 1'b0;
    bus.ex_mem_read     = 1'b0;
    bus.ex_rd_addr      = 5'd0;
    bus.ex_branch_taken = 1'b0;
    bus.mem_req         = 1'b0;
    bus.mem_ready       = 1'b0;
  endtask

  task automatic clr_sat();
    sbus.id_rs1_addr     = 5'd0;
    sbus.id_rs2_addr     = 5'd0;
    sbus.id_uses_rs1     = 1'b0;
    sbus.id_uses_rs2     = 1'b0;
    sbus.ex_mem_read     = 1'b0;
    sbus.ex_rd_addr      = 5'd0;
    sbus.ex_branch_taken = 1'b0;
    sbus.mem_req         = 1'b0;
    sbus.mem_ready       = 1'b0;
  endtask

  task automatic set_hazard(input logic [4:0] rd, input logic [4:0] rs1, input logic u1,
                            input logic [4:0] rs2, input logic u2, input logic ld);
    bus.ex_rd_addr  = rd;
    bus.id_rs1_addr = rs1;
    bus.id_uses_rs1 = u1;
    bus.id_rs2_addr = rs2;
    bus.id_uses_rs2 = u2;
    bus.ex_mem_read = ld;
  endtask

  initial begin
    reset   = 1'b1;
    rst_sat = 1'b1;
    clr_in();
    clr_sat();
    #1;
    chk("rst_ctrl_during_reset", 32'(ctrl), 32'(C_NORMAL));
    tick();
    tick();
    reset   = 1'b0;
    rst_sat = 1'b0;
    chk("rst_stall", 32'(bus.stall_cycles), 32'd0);
    chk("rst_flush", 32'(bus.flush_count), 32'd0);
    chk("rst_state", 32'(dut.state_q), 32'(S_RUN));
    chk("rst_ctrl", 32'(ctrl), 32'(C_NORMAL));

    // load-use on rs2
    set_hazard(5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
    #1;
    chk("lu_rs2_ctrl", 32'(ctrl), 32'(C_LDUSE));
    tick();
    clr_in();
    chk("lu_rs2_stall", 32'(bus.stall_cycles), 32'd1);

    // same hazard against x0 is not a hazard
    set_hazard(5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1);
    #1;
    chk("lu_x0_ctrl", 32'(ctrl), 32'(C_NORMAL));
    tick();
    clr_in();
    chk("lu_x0_stall", 32'(bus.stall_cycles), 32'd1);

    // load-use on rs1
    set_hazard(5'd7, 5'd7, 1'b1, 5'd0, 1'b0, 1'b1);
    #1;
    chk("lu_rs1_ctrl", 32'(ctrl), 32'(C_LDUSE));
    tick();
    clr_in();
    chk("lu_rs1_stall", 32'(bus.stall_cycles), 32'd2);

    // matching rs1 but not used
    set_hazard(5'd7, 5'd7, 1'b0, 5'd3, 1'b1, 1'b1);
    #1;
    chk("lu_unused_ctrl", 32'(ctrl), 32'(C_NORMAL));
    // matching rs2 but EX is not a load
    set_hazard(5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0);
    #1;
    chk("lu_noload_ctrl", 32'(ctrl), 32'(C_NORMAL));
    clr_in();

    // branch beats load-use
    set_hazard(5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
    bus.ex_branch_taken = 1'b1;
    #1;
    chk("br_lu_ctrl", 32'(ctrl), 32'(C_BRANCH));
    tick();
    clr_in();
    chk("br_lu_flush", 32'(bus.flush_count), 32'd1);
    chk("br_lu_stall", 32'(bus.stall_cycles), 32'd2);

    // 3-cycle memory wait, branch during freeze is ignored
    bus.mem_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.ex_branch_taken = (i == 1);
      #1;
      chk("mw_freeze_ctrl", 32'(ctrl), 32'(C_FREEZE));
      tick();
      chk("mw_state", 32'(dut.state_q), 32'(S_WAIT));
    end
    bus.ex_branch_taken = 1'b0;
    chk("mw_stall", 32'(bus.stall_cycles), 32'd5);
    chk("mw_flush", 32'(bus.flush_count), 32'd1);
    bus.mem_ready = 1'b1;
    #1;
    chk("mw_ready_ctrl", 32'(ctrl), 32'(C_NORMAL));
    tick();
    chk("mw_ready_state", 32'(dut.state_q), 32'(S_RUN));
    chk("mw_ready_stall", 32'(bus.stall_cycles), 32'd5);
    clr_in();

    // leave MEM_WAIT by dropping mem_req
    bus.mem_req = 1'b1;
    tick();
    chk("mw2_state", 32'(dut.state_q), 32'(S_WAIT));
    bus.mem_req = 1'b0;
    #1;
    chk("mw2_ctrl", 32'(ctrl), 32'(C_NORMAL));
    tick();
    chk("mw2_exit_state", 32'(dut.state_q), 32'(S_RUN));
    chk("mw2_stall", 32'(bus.stall_cycles), 32'd6);

    // timeout with MEM_TIMEOUT=4: ERROR after 5th freeze edge
    bus.mem_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("to_freeze_ctrl", 32'(ctrl), 32'(C_FREEZE));
      tick();
      if (i == 3) chk("to_state_before", 32'(dut.state_q), 32'(S_WAIT));
    end
    chk("to_state", 32'(dut.state_q), 32'(S_ERR));
    chk("to_ctrl", 32'(ctrl), 32'(C_ERROR));
    chk("to_stall", 32'(bus.stall_cycles), 32'd11);
    set_hazard(5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
    bus.ex_branch_taken = 1'b1;
    #1;
    chk("err_ctrl_hazards", 32'(ctrl), 32'(C_ERROR));
    tick();
    tick();
    chk("err_stall_frozen", 32'(bus.stall_cycles), 32'd11);
    chk("err_flush_frozen", 32'(bus.flush_count), 32'd1);
    clr_in();
    tick();
    chk("err_sticky", 32'(ctrl), 32'(C_ERROR));

    // reset out of ERROR
    reset = 1'b1;
    #1;
    chk("err_rst_ctrl", 32'(ctrl), 32'(C_NORMAL));
    tick();
    reset = 1'b0;
    chk("err_rst_state", 32'(dut.state_q), 32'(S_RUN));
    chk("err_rst_stall", 32'(bus.stall_cycles), 32'd0);
    chk("err_rst_flush", 32'(bus.flush_count), 32'd0);
    chk("err_rst_ctrl2", 32'(ctrl), 32'(C_NORMAL));

    // reset in the middle of MEM_WAIT
    bus.mem_req = 1'b1;
    tick();
    tick();
    chk("mid_state", 32'(dut.state_q), 32'(S_WAIT));
    chk("mid_stall", 32'(bus.stall_cycles), 32'd2);
    reset = 1'b1;
    #1;
    chk("mid_rst_ctrl", 32'(ctrl), 32'(C_FREEZE));
    tick();
    chk("mid_rst_state", 32'(dut.state_q), 32'(S_RUN));
    chk("mid_rst_stall", 32'(bus.stall_cycles), 32'd0);
    reset = 1'b0;
    clr_in();

    // stall_cycles saturation on the long-timeout instance
    chk("sat_start", 32'(sbus.stall_cycles), 32'd0);
    sbus.mem_req = 1'b1;
    for (int i = 0; i < 65535; i++) tick();
    chk("sat_stall", 32'(sbus.stall_cycles), 32'hFFFF);
    chk("sat_state", 32'(u_sat.state_q), 32'(S_WAIT));
    sbus.mem_req = 1'b0;
    tick();
    chk("sat_run", 32'(u_sat.state_q), 32'(S_RUN));
    sbus.mem_req = 1'b1;
    tick();
    tick();
    chk("sat_freeze_hold", 32'(sbus.stall_cycles), 32'hFFFF);
    sbus.mem_req     = 1'b0;
    sbus.ex_mem_read = 1'b1;
    sbus.ex_rd_addr  = 5'd9;
    sbus.id_rs1_addr = 5'd9;
    sbus.id_uses_rs1 = 1'b1;
    tick();
    chk("sat_lu_hold", 32'(sbus.stall_cycles), 32'hFFFF);
    clr_sat();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 Parameter: MEM_TIMEOUT, 255, max consecutive mem-wait cycles before error (1..65535).
REQ-002 Ports, one per line: name direction width meaning.
- clk in 1 clock
- reset in 1 synchronous active-high reset
- id_rs1_addr in 5 rs1 index of ID-stage instr
- id_rs2_addr in 5 rs2 index of ID-stage instr
- id_uses_rs1 in 1 ID instr reads rs1
- id_uses_rs2 in 1 ID instr reads rs2
- ex_mem_read in 1 EX-stage instr is a load
- ex_rd_addr in 5 EX-stage destination index
- ex_branch_taken in 1 EX-stage branch resolved taken
- mem_req in 1 MEM-stage instr accesses data memory
- mem_ready in 1 data memory completes access this cycle
- pc_en out 1 PC update enable
- pc_sel_branch out 1 select branch target for next PC
- ifid_en out 1 IF/ID register load enable
- ifid_flush out 1 IF/ID clear to NOP
- idex_en out 1 ID/EX register load enable
- idex_flush out 1 ID/EX load bubble (all control 0)
- exmem_en out 1 EX/MEM register load enable
- memwb_flush out 1 MEM/WB load bubble
- mem_timeout out 1 sticky memory-timeout error
- stall_cycles out 16 saturating count of stall/freeze cycles
- flush_count out 16 saturating count of branch flushes
REQ-003 Design SHALL have one clock, clk; reset SHALL be synchronous and active-high.

Function
REQ-004 States SHALL be RUN, MEM_WAIT, ERROR; enable/flush outputs SHALL be combinational from state and inputs (zero-cycle latency).
REQ-005 freeze = (state is RUN or MEM_WAIT) && mem_req && !mem_ready.
REQ-006 load_use = ex_mem_read && ex_rd_addr!=0 && ((id_uses_rs1 && id_rs1_addr==ex_rd_addr) || (id_uses_rs2 && id_rs2_addr==ex_rd_addr)).
REQ-007 Priority: ERROR > freeze > branch > load_use > normal.
REQ-008 Normal: all *_en=1, all flushes=0, pc_sel_branch=0.
REQ-009 Freeze: pc_en=ifid_en=idex_en=exmem_en=0, memwb_flush=1, other flushes and pc_sel_branch=0; branch and load_use ignored.
REQ-010 Branch (ex_branch_taken, no freeze): pc_en=1, pc_sel_branch=1, ifid_flush=1, idex_flush=1, other enables=1; load_use ignored.
REQ-011 Load_use (no freeze, no branch): pc_en=0, ifid_en=0, idex_flush=1, idex_en=1, exmem_en=1; exactly one bubble per hazard cycle.
REQ-012 ERROR: all enables 0, all flushes 0, pc_sel_branch=0, mem_timeout=1.
REQ-013 RUN->MEM_WAIT when freeze; 16-bit wait_cnt loads 1.
REQ-014 MEM_WAIT->RUN when mem_ready=1 or mem_req=0; wait_cnt clears.
REQ-015 MEM_WAIT while freeze: wait_cnt increments; if wait_cnt==MEM_TIMEOUT at that edge, next state ERROR.
REQ-016 ERROR SHALL be exited only by reset; mem_timeout stays 1 until reset.
REQ-017 stall_cycles SHALL increment each cycle freeze or load_use stall is applied, saturating at 0xFFFF; not counted in ERROR.
REQ-018 flush_count SHALL increment each cycle the branch case (REQ-010) applies, saturating at 0xFFFF.

Reset
REQ-019 On reset: state RUN, wait_cnt 0, stall_cycles 0, flush_count 0, mem_timeout 0; reset SHALL override all inputs, including mid-MEM_WAIT and in ERROR.
REQ-020 During reset cycle outputs SHALL reflect state RUN with current inputs.

Verification
REQ-021 ex_mem_read=1, ex_rd_addr=5, id_rs2_addr=5, id_uses_rs2=1 for 1 cycle -> pc_en=0, ifid_en=0, idex_flush=1; stall_cycles 0->1.
REQ-022 Same hazard but ex_rd_addr=0 -> normal outputs, stall_cycles unchanged.
REQ-023 ex_branch_taken=1 together with load_use -> pc_sel_branch=1, ifid_flush=1, idex_flush=1, pc_en=1; flush_count +1, stall_cycles unchanged.
REQ-024 mem_req=1, mem_ready=0 for 3 cycles then mem_ready=1 -> freeze outputs 3 cycles, state MEM_WAIT, normal on 4th cycle, RUN next, stall_cycles +3.
REQ-025 MEM_TIMEOUT=4, mem_req=1, mem_ready held 0 -> ERROR after 5th freeze edge, mem_timeout=1, all enables 0; reset -> RUN, counters 0, mem_timeout 0.
REQ-026 Preload stall_cycles to 0xFFFF via continuous freeze -> stays 0xFFFF on further stalls.
